// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Round-robin arbiter that shares one byte-level SPI engine between NUM_REQ
//   requesters. Each requester owns one chip select. A granted requester keeps
//   the engine until it hands over a byte marked tx_last. Only then does the
//   chip select rise and the grant move on.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound the idle wait in XFER.
//   The limit is TIMEOUT_CYCLES. On expiry, timeout_err pulses and the
//   transaction is closed through the normal CS_HOLD release.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   req                   per-requester bus request (level, sampled in IDLE)
//   gnt                   one-hot grant, held for the whole transaction
//   tx_valid/last/data    per-requester byte stream (data packed 8 bits each)
//   tx_ready              byte accept, only for the granted requester in XFER
//   rx_valid/rx_data      received byte, pulsed to the granted requester
//   eng_start/eng_tx      start pulse and byte to the SPI byte engine
//   eng_done/eng_rx       engine completion pulse and received byte
//   cs_n                  active-low chip selects (at most one low)
//   timeout_err           XFER idle timeout pulse (SPI_ARB_TIMEOUT_EN only)
module spi_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CS_SETUP       = 2,
    parameter int CS_HOLD        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic [NUM_REQ-1:0]   tx_valid,
    input  logic [NUM_REQ-1:0]   tx_last,
    input  logic [NUM_REQ*8-1:0] tx_data,
    output logic [NUM_REQ-1:0]   tx_ready,
    output logic [NUM_REQ-1:0]   rx_valid,
    output logic [7:0]           rx_data,
    output logic                 eng_start,
    output logic [7:0]           eng_tx,
    input  logic                 eng_done,
    input  logic [7:0]           eng_rx,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 timeout_err
`else
    output logic [NUM_REQ-1:0]   cs_n
`endif
);

    localparam int MAXV_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAXV   = (MAXV_A > TIMEOUT_CYCLES) ? MAXV_A : TIMEOUT_CYCLES;
    localparam int CW     = (MAXV < 2) ? 1 : $clog2(MAXV);
    localparam int PW     = $clog2(NUM_REQ);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WAIT, S_HOLD} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [PW-1:0]        r_ptr, r_gidx, w_pick;
    logic                 w_found;
    logic [NUM_REQ-1:0]   r_gnt, r_rx_valid;
    logic                 r_last, r_eng_start;
    logic [7:0]           r_eng_tx, r_rx_data;
    logic                 w_grant, w_hs, w_done, w_release;
`ifdef SPI_ARB_TIMEOUT_EN
    logic                 w_timeout, r_timeout_err;
`endif

    // Search upward from r_ptr with wrap. Iterating from the largest offset
    // down means the smallest offset written last wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A zero-length SETUP or HOLD is skipped entirely, so the latencies stay
    // CS_SETUP+1 and CS_HOLD+1 even at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_hs        = 1'b0;
        w_done      = 1'b0;
        w_release   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (CS_SETUP == 0) ? S_XFER : S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == CW'(CS_SETUP - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_XFER;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_XFER: begin
                if (tx_valid[r_gidx]) begin
                    w_hs        = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_release   = (CS_HOLD == 0);
                    w_state_nxt = (CS_HOLD == 0) ? S_IDLE : S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (eng_done) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = '0;
                    if (r_last) begin
                        w_release   = (CS_HOLD == 0);
                        w_state_nxt = (CS_HOLD == 0) ? S_IDLE : S_HOLD;
                    end else begin
                        w_state_nxt = S_XFER;
                    end
                end
            end
            S_HOLD: begin
                if (r_cnt == CW'(CS_HOLD - 1)) begin
                    w_release   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ptr         <= '0;
            r_gidx        <= '0;
            r_gnt         <= '0;
            r_last        <= 1'b0;
            r_eng_start   <= 1'b0;
            r_eng_tx      <= '0;
            r_rx_valid    <= '0;
            r_rx_data     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_eng_start   <= w_hs;
            r_rx_valid    <= w_done ? r_gnt : '0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_timeout_err <= w_timeout;
`endif
            if (w_grant) begin
                r_gnt  <= NUM_REQ'(1) << w_pick;
                r_gidx <= w_pick;
            end
            if (w_release) begin
                r_gnt <= '0;
                r_ptr <= (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
            if (w_hs) begin
                r_eng_tx <= tx_data[int'(r_gidx)*8 +: 8];
                r_last   <= tx_last[r_gidx];
            end
            if (w_done) r_rx_data <= eng_rx;
        end
    end

    assign gnt       = r_gnt;
    assign cs_n      = ~r_gnt;
    assign tx_ready  = (r_state == S_XFER) ? r_gnt : '0;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign eng_start = r_eng_start;
    assign eng_tx    = r_eng_tx;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;
    localparam int N  = 4;
    localparam int SU = 2;
    localparam int HO = 2;
    localparam int TO = 16;

    logic           aclk = 1'b0;
    logic           areset;
    logic [N-1:0]   req, tx_valid, tx_last;
    logic [N*8-1:0] tx_data;
    logic           eng_done;
    logic [7:0]     eng_rx;
    logic [N-1:0]   gnt, tx_ready, rx_valid, cs_n;
    logic [7:0]     rx_data, eng_tx;
    logic           eng_start;
`ifdef SPI_ARB_TIMEOUT_EN
    logic           timeout_err;
`endif

    spi_master_arbiter #(.NUM_REQ(N), .CS_SETUP(SU), .CS_HOLD(HO), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .areset(areset), .req(req), .gnt(gnt),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .eng_start(eng_start), .eng_tx(eng_tx),
        .eng_done(eng_done), .eng_rx(eng_rx),
`ifdef SPI_ARB_TIMEOUT_EN
        .cs_n(cs_n), .timeout_err(timeout_err)
`else
        .cs_n(cs_n)
`endif
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;   // model round-robin pointer

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge aclk);
    endtask

    // Reference arbitration: first requesting index at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Random noise on every requester other than g; must never reach the engine.
    task automatic junk(input int g);
        for (int i = 0; i < N; i++) begin
            if (i != g) begin
                tx_valid[i]       = 1'($urandom_range(0, 1));
                tx_last[i]        = 1'($urandom_range(0, 1));
                tx_data[i*8 +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_cs_n"}, cs_n, 4'hF);
        chk({tag, "_tx_ready"}, tx_ready, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_eng_tx"}, eng_tx, 0);
`ifdef SPI_ARB_TIMEOUT_EN
        chk({tag, "_timeout_err"}, timeout_err, 0);
`endif
    endtask

    task automatic do_reset();
        areset = 1'b1;
        req = '0;
        tx_valid = '0;
        eng_done = 1'b0;
        nclk();
        nclk();
        areset = 1'b0;
        ptr_m = 0;
    endtask

    // Full check of the release: cs_n low for HO-1 more cycles after rx_valid, then high.
    task automatic check_release(input logic [N-1:0] oh, input logic [N-1:0] ohn);
        for (int k = 1; k < HO; k++) begin
            nclk();
            chk("hold_cs_low", cs_n, ohn);
            chk("hold_gnt", gnt, oh);
        end
        nclk();
        chk("release_cs_high", cs_n, 4'hF);
        chk("release_gnt", gnt, 0);
    endtask

    task automatic run_txn(input logic [N-1:0] m, input int nb, input bit drop,
                           input bit rst_mid, output int g);
        logic [N-1:0] oh, ohn, last_rdy;
        logic [7:0]   b, r;
        int           k, gap, d;
        g   = pick(m, ptr_m);
        oh  = N'(1) << g;
        ohn = ~oh;
        req = m;
        junk(g);
        tx_valid[g] = 1'b0;
        nclk();
        chk("grant_gnt", gnt, oh);
        chk("grant_cs_n", cs_n, ohn);
        for (int i = 0; i < nb; i++) begin
            last_rdy = tx_ready;
            gap = (i == 0) ? 0 : $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                junk(g);
                nclk();
                chk("gap_cs_low", cs_n, ohn);
                last_rdy = tx_ready;
            end
            b = 8'($urandom);
            junk(g);
            tx_valid[g] = 1'b1;
            tx_data[g*8 +: 8] = b;
            tx_last[g] = (i == nb - 1);
            k = 0;
            forever begin
                nclk();
                k++;
                if (eng_start || k >= 40) break;
                chk("rdy_only_granted", tx_ready & ohn, 0);
                last_rdy = tx_ready;
            end
            tx_valid[g] = 1'b0;
            chk("start_latency", k, (i == 0) ? SU + 1 : 1);
            chk("rdy_at_handshake", last_rdy, oh);
            chk("eng_tx", eng_tx, b);
            chk("xfer_cs_low", cs_n, ohn);
            if (drop && i == 0) req = m & ohn;
            if (rst_mid) begin
                areset = 1'b1;
                req = '0;
                nclk();
                chk_reset_vals("rst_mid");
                areset = 1'b0;
                eng_done = 1'b1;
                eng_rx = 8'($urandom);
                nclk();
                eng_done = 1'b0;
                chk("late_done_no_rx", rx_valid, 0);
                chk("late_done_cs", cs_n, 4'hF);
                ptr_m = 0;
                return;
            end
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                junk(g);
                nclk();
                chk("eng_tx_stable", eng_tx, b);
                chk("wait_no_rx", rx_valid, 0);
                chk("wait_no_rdy", tx_ready, 0);
            end
            r = 8'($urandom);
            eng_done = 1'b1;
            eng_rx = r;
            nclk();
            eng_done = 1'b0;
            eng_rx = 8'($urandom);
            chk("rx_valid", rx_valid, oh);
            chk("rx_data", rx_data, r);
            chk("rx_cs_low", cs_n, ohn);
        end
        check_release(oh, ohn);
        ptr_m = (g + 1) % N;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic run_timeout(input logic [N-1:0] m);
        logic [N-1:0] oh, ohn;
        int g, k;
        g   = pick(m, ptr_m);
        oh  = N'(1) << g;
        ohn = ~oh;
        req = m;
        junk(g);
        tx_valid[g] = 1'b0;
        nclk();
        chk("to_grant", gnt, oh);
        k = 0;
        forever begin
            junk(g);
            tx_valid[g] = 1'b0;
            nclk();
            k++;
            if (timeout_err || k >= 100) break;
            chk("to_cs_low", cs_n, ohn);
        end
        chk("timeout_latency", k, SU + TO);
        nclk();
        chk("timeout_pulse", timeout_err, 0);
        chk("to_hold_cs_low", cs_n, ohn);
        for (int j = 2; j < HO; j++) nclk();
        nclk();
        chk("to_release_cs", cs_n, 4'hF);
        chk("to_release_gnt", gnt, 0);
        ptr_m = (g + 1) % N;
    endtask
`endif

    initial begin
        int g;
        logic [N-1:0] m;
        req = '0; tx_valid = '0; tx_last = '0; tx_data = '0;
        eng_done = 1'b0; eng_rx = '0;
        do_reset();
        chk_reset_vals("reset");

        // Single byte on requester 0, then a three-byte burst on requester 2.
        run_txn(4'b0001, 1, 0, 0, g);
        chk("single_g", g, 0);
        run_txn(4'b0100, 3, 0, 0, g);
        chk("burst_g", g, 2);

        // Round-robin with all requests held: 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'hF, $urandom_range(1, 2), 0, 0, g);
            chk("rr_order", g, i % N);
        end

        // Requester 1 drops req after the first of two bytes.
        run_txn(4'b0010, 2, 1, 0, g);
        chk("drop_g", g, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 25; i++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            run_txn(m, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, g);
        end

        // Reset while a byte is outstanding, then confirm the pointer restarted.
        run_txn(4'b1100, 2, 0, 1, g);
        run_txn(4'b1001, 1, 0, 0, g);
        chk("post_reset_ptr", g, 0);

`ifdef SPI_ARB_TIMEOUT_EN
        run_timeout(4'b0110);
        run_txn(4'b0110, 1, 0, 0, g);
        chk("after_timeout_next", g, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one byte-level SPI engine between NUM_REQ requesters, using round-robin arbitration.
- Each requester owns one chip select.
- A granted requester streams bytes until it marks one byte as last; only then is the engine handed on.
- Sits between the AXI-Lite/user-side requesters and the SPI byte engine that drives spi_sclk/spi_mosi/spi_miso.

Parameters:
- NUM_REQ, 4: number of requesters and chip selects (2..8).
- CS_SETUP, 2: aclk cycles from cs_n falling to the first eng_start (0 allowed).
- CS_HOLD, 2: aclk cycles from the last eng_done to cs_n rising (0 allowed).
- TIMEOUT_CYCLES, 1024: idle-wait limit in XFER; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester bus request (level).
- gnt  out  NUM_REQ  one-hot grant; held for the whole transaction.
- tx_valid  in  NUM_REQ  per-requester byte valid.
- tx_last  in  NUM_REQ  marks the final byte of a transaction.
- tx_data  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- tx_ready  out  NUM_REQ  byte accepted when tx_valid[i] and tx_ready[i] are both high.
- rx_valid  out  NUM_REQ  one-cycle pulse per received byte, to the granted requester only.
- rx_data  out  8  received byte; valid when any rx_valid bit is high.
- eng_start  out  1  one-cycle start pulse to the SPI byte engine.
- eng_tx  out  8  byte to shift out; stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse when the engine finishes a byte.
- eng_rx  in  8  byte shifted in; valid with eng_done.
- cs_n  out  NUM_REQ  active-low chip selects; at most one bit low.
- timeout_err  out  1  one-cycle pulse; present only with SPI_ARB_TIMEOUT_EN.

Behaviour:
- Reset values, applied when areset=1 at a rising edge:
  - state=IDLE; round-robin pointer = requester 0 has highest priority.
  - gnt=0, tx_ready=0, rx_valid=0, rx_data=0, eng_start=0, eng_tx=0, cs_n=all 1, timeout_err=0.
- Reset mid-transaction: abort immediately. cs_n rises and the grant drops on the next edge. Any in-flight engine byte is discarded (a later eng_done is ignored in IDLE).
- State machine states: IDLE, SETUP, XFER, WAIT, HOLD.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from pointer, with wrap.
  - Next edge: gnt[g]=1, cs_n[g]=0, setup counter = 0, state = SETUP (or XFER directly if CS_SETUP=0).
  - req is sampled only in IDLE. Dropping req after grant has no effect; the transaction ends only on tx_last.
- SETUP: count CS_SETUP cycles, then go to XFER.
- XFER:
  - tx_ready[g]=1; all other tx_ready bits = 0.
  - On handshake: register eng_tx=tx_data[g] and the last flag, pulse eng_start for one cycle, go to WAIT.
- WAIT:
  - tx_ready=0. On eng_done: rx_data=eng_rx and rx_valid[g]=1 for one cycle.
  - Then go to HOLD if the last flag is set, otherwise back to XFER.
  - eng_done and a new handshake can never coincide, because tx_ready is low in WAIT.
- HOLD:
  - Count CS_HOLD cycles.
  - Next edge: cs_n[g]=1, gnt=0, pointer = g+1 mod NUM_REQ, state = IDLE.
  - IDLE always lasts at least one cycle, so cs_n is high for at least one cycle between transactions.
- Latency:
  - req to gnt/cs_n low: 1 cycle.
  - cs_n low to eng_start: CS_SETUP+1 cycles minimum.
  - eng_done to rx_valid: 1 cycle.
  - Last eng_done to cs_n high: CS_HOLD+1 cycles.
- Fairness: a requester that keeps req high cannot win twice in a row while another req bit is set.
- A single-byte transaction has tx_last=1 on its first byte.
- Counters are sized to the maximum of CS_SETUP, CS_HOLD and TIMEOUT_CYCLES (clog2, minimum 1 bit). They never wrap within a state.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- When defined:
  - In XFER, a counter increments each cycle without a handshake.
  - On reaching TIMEOUT_CYCLES, timeout_err pulses and the state goes to HOLD. Normal CS_HOLD release and pointer advance follow.
  - The counter clears on entry to XFER.
- When undefined: the timeout_err port and counter are absent, and XFER waits indefinitely.

Test Plan:
- Single byte, requester 0, CS_SETUP=2, CS_HOLD=2:
  - Stimulus: req=0001; tx_data=0xA5 with tx_last=1; engine returns 0x3C.
  - Required: cs_n=1110 one cycle after req; eng_start 3 cycles after cs_n falls; eng_tx=0xA5; rx_valid=0001 with rx_data=0x3C; cs_n=1111 3 cycles after eng_done.
- Three-byte burst, requester 2:
  - Stimulus: bytes 0x11, 0x22, 0x33, last on the third.
  - Required: cs_n[2] stays low throughout; three eng_start pulses; three rx_valid[2] pulses; gnt=0100 until HOLD completes.
- Round-robin, req=1111 held high:
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: cs_n never shows two bits low, and is all-high for at least one cycle between grants.
- Requester drops req after grant:
  - Stimulus: requester 1 is granted and sends 2 bytes; req[1] falls before the second byte.
  - Required: the transaction still completes; cs_n[1] rises only after tx_last.
- Reset mid-WAIT:
  - Stimulus: assert areset while eng_start is outstanding, then pulse eng_done.
  - Required: all outputs return to reset values on the next edge; the late eng_done produces no rx_valid.
- Timeout with SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Stimulus: the granted requester never asserts tx_valid.
  - Required: timeout_err pulses after 16 XFER cycles; cs_n rises after CS_HOLD; the next requester is granted.
